// File: rtl/e_muldiv.sv
// e_muldiv: multi-cycle multiply/divide unit with HI/LO registers for the
// execute stage. A mult/div request latches its operands, holds busy for a
// fixed number of cycles, then commits the result to HI/LO in one edge.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | no operation in flight; start, mthi and mtlo are accepted
// S_BUSY | mult/div in flight; counter runs down, commit when it reads 1
module e_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        is_muldiv;
    logic        is_mul;
    logic        signed_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, div_den;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        commit_en;

    assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign start     = is_muldiv && !busy_q;

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // mfhi/mflo read port; every other op reads as zero
    always_comb begin
        out = 32'd0;
        if (op == OP_MFHI) begin
            out = hi_q;
        end else if (op == OP_MFLO) begin
            out = lo_q;
        end
    end

    // Result datapath from the latched operands. Signed divide works on
    // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
    always_comb begin
        prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        signed_div = (op_q == OP_DIV);
        a_mag      = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag      = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
        div_den    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / div_den;
        r_mag      = a_mag % div_den;
        quot       = (signed_div && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem        = (signed_div && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
        commit_en  = 1'b1;
        res_hi     = hi_q;
        res_lo     = lo_q;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi    = rem;
                res_lo    = quot;
                commit_en = (b_q != 32'd0);
            end
            default: commit_en = 1'b0;
        endcase
    end

    // Next-state: start/mthi/mtlo when idle, countdown and commit when busy
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = is_mul ? MULT_LOAD : DIV_LOAD;
                    op_d    = op;
                    a_d     = rs;
                    b_d     = rt;
                end else if (op == OP_MTHI) begin
                    hi_d = rs;
                end else if (op == OP_MTLO) begin
                    lo_d = rs;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (commit_en) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and register file; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Testbench for e_muldiv: scoreboard of expected HI/LO/busy-length per
// operation, pushed at issue and popped when the unit goes idle.
module tb_e_muldiv;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        start, busy;
    logic [31:0] hi, lo, out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_muldiv #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .op(op), .rs(rs), .rt(rt),
        .start(start), .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    always #5 clk = ~clk;

    // Reference model: 64-bit arithmetic on extended operands
    task automatic push_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        e.cycles = (o == 4'd1 || o == 4'd2) ? MULT_CYCLES : DIV_CYCLES;
        sa  = longint'(signed'(a));
        sbv = longint'(signed'(b));
        case (o)
            4'd1: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd3: if (b != 0) begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
            4'd4: if (b != 0) begin e.lo = a / b; e.hi = a % b; end
            default: ;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
    endtask

    // Drive one op right after a rising edge
    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op = o; rs = a; rt = b;
    endtask

    // Count busy cycles at falling edges until idle, bounded
    task automatic wait_idle(output int cyc, output bit to);
        cyc = 0; to = 0;
        @(negedge clk);
        while (busy === 1'b1) begin
            cyc++;
            if (cyc > 100) begin to = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 4'd0; rs = 32'd0; rt = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
        n_cmp++; if (out !== 32'd0 || start !== 1'b0) begin n_err++; $display("FAIL reset_out got out=%h start=%0b want 0/0", out, start); end
    endtask

    // Start a mult/div with optional rs change while busy, then check scoreboard
    task automatic run_check(input string name, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b, input bit clobber);
        exp_t e; int cyc; bit to;
        push_op(o, a, b);
        drive(o, a, b);
        @(negedge clk);
        n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL %s_start got %0b want 1", name, start); end
        @(posedge clk); #1;
        op = 4'd0;
        if (clobber) begin rs = 32'd0; rt = 32'd3; end
        wait_idle(cyc, to);
        e = sb.pop_front();
        n_cmp++; if (to || cyc != e.cycles) begin n_err++; $display("FAIL %s_busy_len got %0d want %0d", name, cyc, e.cycles); end
        n_cmp++; if (hi !== e.hi || lo !== e.lo) begin n_err++; $display("FAIL %s_result got %h/%h want %h/%h", name, hi, lo, e.hi, e.lo); end
    endtask

    task automatic test_mult();
        run_check("mult", 4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        n_cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mult_const got %h/%h want ffffffff/fffffffe", hi, lo); end
        drive(4'd5, 32'd0, 32'd0);
        @(negedge clk);
        n_cmp++; if (out !== 32'hFFFFFFFF || start !== 1'b0) begin n_err++; $display("FAIL mfhi got %h want ffffffff", out); end
        drive(4'd6, 32'd0, 32'd0);
        @(negedge clk);
        n_cmp++; if (out !== m_lo) begin n_err++; $display("FAIL mflo got %h want %h", out, m_lo); end
        drive(4'd12, 32'd0, 32'd0);
        @(negedge clk);
        n_cmp++; if (out !== 32'd0 || start !== 1'b0) begin n_err++; $display("FAIL op12_out got %h want 0", out); end
    endtask

    task automatic test_multu();
        run_check("multu", 4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        n_cmp++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_const got %h/%h want 00000001/fffffffe", hi, lo); end
    endtask

    task automatic test_div();
        run_check("div_neg", 4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        n_cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_const got %h/%h want ffffffff/fffffffd", hi, lo); end
        run_check("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_const got %h/%h want 0/80000000", hi, lo); end
        run_check("divu", 4'd4, 32'hFFFFFFF0, 32'h00000007, 1'b1);
    endtask

    task automatic test_mthi_mtlo_divzero();
        drive(4'd7, 32'h12345678, 32'd0);
        @(negedge clk);
        n_cmp++; if (hi !== m_hi) begin n_err++; $display("FAIL mthi_early got %h want %h", hi, m_hi); end
        drive(4'd8, 32'h9ABCDEF0, 32'd0);
        m_hi = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (hi !== 32'h12345678) begin n_err++; $display("FAIL mthi got %h want 12345678", hi); end
        drive(4'd0, 32'd0, 32'd0);
        m_lo = 32'h9ABCDEF0;
        @(negedge clk);
        n_cmp++; if (lo !== 32'h9ABCDEF0) begin n_err++; $display("FAIL mtlo got %h want 9abcdef0", lo); end
        run_check("divu_zero", 4'd4, 32'd55, 32'd0, 1'b0);
        run_check("div_zero", 4'd3, 32'hFFFFFF00, 32'd0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        exp_t e; int cyc; bit to;
        push_op(4'd1, 32'h00012345, 32'h00067890);
        drive(4'd1, 32'h00012345, 32'h00067890);
        @(posedge clk); #1;
        op = 4'd3; rs = 32'd9; rt = 32'd2;
        @(negedge clk);
        n_cmp++; if (start !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL ignore_div got start=%0b busy=%0b want 0/1", start, busy); end
        @(posedge clk); #1;
        op = 4'd7; rs = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL ignore_mthi_start got %0b want 0", start); end
        @(posedge clk); #1;
        op = 4'd0;
        wait_idle(cyc, to);
        e = sb.pop_front();
        n_cmp++; if (to || cyc + 2 != e.cycles) begin n_err++; $display("FAIL ignore_busy_len got %0d want %0d", cyc + 2, e.cycles); end
        n_cmp++; if (hi !== e.hi || lo !== e.lo) begin n_err++; $display("FAIL ignore_result got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        push_op(4'd4, 32'd100, 32'd7);
        drive(4'd4, 32'd100, 32'd7);
        @(posedge clk); #1;
        op = 4'd0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        e = sb.pop_front();
        m_hi = 32'd0; m_lo = 32'd0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %0b want 0", busy); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL async_hilo got %h/%h want 0/0", hi, lo); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL async_no_commit got busy=%0b %h/%h want 0 %h/%h", busy, hi, lo, m_hi, m_lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo_divzero();
        test_busy_ignore();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/e_muldiv.md
Name: e_muldiv

Overview:
Multi-cycle multiply/divide unit with HI/LO registers, instantiated in the execute stage of the five-stage pipeline. It consumes forwarded rs/rt operands and a decoded HI/LO operation code, and produces the mfhi/mflo read value, which the pipeline carries forward as the HILO result. Its busy output feeds the stall unit, which holds any HI/LO-class instruction in decode while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (min 1)
DIV_CYCLES, 10, busy cycles for div/divu (min 1)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none
rs  input  32  forwarded rs operand
rt  input  32  forwarded rt operand
start  output  1  combinational: op in {1,2,3,4} and not busy
busy  output  1  registered; high while a mult/div is in flight
hi  output  32  current HI register
lo  output  32  current LO register
out  output  32  combinational read value: hi if op==5, lo if op==6, else 0

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, counter=0, state=IDLE, and any pending result is discarded. After reset deasserts, the unit is idle with out=0.
- States:
  - IDLE -> BUSY on a clock edge where start=1.
  - BUSY -> IDLE on the edge where the counter reaches 1.
- On the start edge:
  - Latch rs, rt and op into internal registers.
  - Load counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
  - Set busy=1.
- In BUSY: decrement the counter each edge. On the edge where the counter reaches 1, write hi/lo from the latched operands and clear busy.
- Timing: a start at edge k gives busy=1 for exactly N cycles (edges k..k+N-1 boundaries), new hi/lo visible after edge k+N, and busy=0 in that same cycle.
- Later operand changes on rs/rt do not affect an in-flight result.
- mult: signed 32x32 -> 64-bit product; hi = product[63:32], lo = product[31:0].
- multu: same split, unsigned product.
- div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (latched rt==0): the operation still runs DIV_CYCLES with busy high, but hi/lo are left unchanged at completion.
- mthi/mtlo:
  - When busy=0, write rs into hi or lo on the next edge.
  - When busy=1, ignore the write (the stall unit guarantees this does not occur).
- mfhi/mflo: out is combinational from the current hi/lo. When busy=1, out reflects the old value; the stall unit prevents such reads.
- op in {1..4} while busy=1: start=0 and the request is ignored; the in-flight operation is unaffected.
- out is 0 for every op other than 5 and 6.

Test Plan:
- Reset, then mult with rs=0xFFFFFFFF, rt=0x00000002 -> start=1 for one cycle; busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; op=5 gives out=0xFFFFFFFF.
- multu with rs=0xFFFFFFFF, rt=0x00000002 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Change rs to 0 during busy -> result unchanged.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. div with 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 -> hi/lo updated one edge each. Then divu with rt=0 -> busy 10 cycles; hi=0x12345678, lo=0x9ABCDEF0 remain.
- Start mult, issue op=3 and op=7 during busy -> start=0, no effect; the mult result commits on schedule.
- Start divu 100/7, assert reset asynchronously mid-cycle at busy cycle 4 -> busy, hi, lo drop to 0 immediately, with no commit afterwards.
